// File: rtl/vec_op_seq_pkg.sv
// Shared definitions for the vector-operation sequencer: opcodes, FSM states
// and the read-to-write pipeline depth.
package vec_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;

    // Cycles from read issue to the matching write strobe.
    localparam int SEQ_LAT = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/vec_op_seq_if.sv
// Bundle of command, scratchpad, ALU and status signals around the sequencer.
// slave = sequencer side; master = decoder/scratchpad/ALU side.
interface vec_op_seq_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 11
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_src_a;
    logic [ADDR_W-1:0] cmd_src_b;
    logic [ADDR_W-1:0] cmd_dst;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] cmd_q;
    logic [DATA_W-1:0] cmd_mu;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;

    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] alu_mu;
    logic [DATA_W-1:0] alu_res;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              done;
    logic              err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_len, cmd_q, cmd_mu,
        output cmd_ready,
        output rd_en, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b,
        output alu_op, alu_a, alu_b, alu_q, alu_mu,
        input  alu_res,
        output wr_en, wr_addr, wr_data,
        output done, err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_len, cmd_q, cmd_mu,
        input  cmd_ready,
        input  rd_en, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b,
        input  alu_op, alu_a, alu_b, alu_q, alu_mu,
        output alu_res,
        input  wr_en, wr_addr, wr_data,
        input  done, err
    );

endinterface

// File: rtl/vec_seq_pipe.sv
// Fixed-latency operand/result pipeline: carries element valid and destination
// address from read issue to write strobe, capturing operands and ALU result.
module vec_seq_pipe #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    input  logic [DATA_W-1:0] rd_data_a_i,
    input  logic [DATA_W-1:0] rd_data_b_i,
    input  logic [DATA_W-1:0] alu_res_i,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              busy_o
);
    import vec_pkg::*;

    logic [SEQ_LAT-1:0] stage_vld;
    logic [ADDR_W-1:0]  stage_addr [SEQ_LAT];

    for (genvar gi = 0; gi < SEQ_LAT; gi++) begin : g_stage
        logic              vld_q;
        logic [ADDR_W-1:0] addr_q;
        logic              in_vld;
        logic [ADDR_W-1:0] in_addr;

        if (gi == 0) begin : g_head
            assign in_vld  = issue_i;
            assign in_addr = issue_addr_i;
        end else begin : g_link
            assign in_vld  = stage_vld[gi-1];
            assign in_addr = stage_addr[gi-1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q  <= 1'b0;
                addr_q <= '0;
            end else begin
                vld_q <= in_vld;
                if (in_vld) begin
                    addr_q <= in_addr;
                end
            end
        end

        assign stage_vld[gi]  = vld_q;
        assign stage_addr[gi] = addr_q;
    end

    logic [DATA_W-1:0] alu_a_q, alu_b_q, wr_data_q;

    // Read data arrives while stage 0 is valid; the ALU result while the
    // second-to-last stage is valid. Registers hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            wr_data_q <= '0;
        end else begin
            if (stage_vld[0]) begin
                alu_a_q <= rd_data_a_i;
                alu_b_q <= rd_data_b_i;
            end
            if (stage_vld[SEQ_LAT-2]) begin
                wr_data_q <= alu_res_i;
            end
        end
    end

    assign alu_a_o   = alu_a_q;
    assign alu_b_o   = alu_b_q;
    assign wr_data_o = wr_data_q;
    assign wr_en_o   = stage_vld[SEQ_LAT-1];
    assign wr_addr_o = stage_addr[SEQ_LAT-1];
    assign busy_o    = |stage_vld[SEQ_LAT-2:0];

endmodule

// File: rtl/vec_op_seq.sv
// Command-driven sequencer streaming element pairs from the scratchpad through
// the shared modular ALU and back, one element per clock.
module vec_op_seq #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 11
) (
    input  logic        clk,
    input  logic        rst,
    vec_op_seq_if.slave bus
);
    import vec_pkg::*;

    seq_state_e        state_q, state_d;
    logic              accept, step;
    logic              pipe_busy;

    logic [ADDR_W-1:0] addr_a_q, addr_b_q, addr_w_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] q_q, mu_q;
    logic              err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    accept = 1'b1;
                    if (!is_legal_op(bus.cmd_op) || (bus.cmd_len == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt_q == LEN_W'(1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Only the final write is left once the earlier stages are empty.
                if (!pipe_busy) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_w_q <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            q_q      <= '0;
            mu_q     <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            addr_a_q <= bus.cmd_src_a;
            addr_b_q <= bus.cmd_src_b;
            addr_w_q <= bus.cmd_dst;
            cnt_q    <= bus.cmd_len;
            op_q     <= bus.cmd_op;
            q_q      <= bus.cmd_q;
            mu_q     <= bus.cmd_mu;
            err_q    <= !is_legal_op(bus.cmd_op);
        end else if (step) begin
            // Address counters wrap naturally at 2^ADDR_W.
            addr_a_q <= addr_a_q + ADDR_W'(1);
            addr_b_q <= addr_b_q + ADDR_W'(1);
            addr_w_q <= addr_w_q + ADDR_W'(1);
            cnt_q    <= cnt_q - LEN_W'(1);
        end
    end

    vec_seq_pipe #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_pipe (
        .clk         (clk),
        .rst         (rst),
        .issue_i     (step),
        .issue_addr_i(addr_w_q),
        .rd_data_a_i (bus.rd_data_a),
        .rd_data_b_i (bus.rd_data_b),
        .alu_res_i   (bus.alu_res),
        .alu_a_o     (bus.alu_a),
        .alu_b_o     (bus.alu_b),
        .wr_en_o     (bus.wr_en),
        .wr_addr_o   (bus.wr_addr),
        .wr_data_o   (bus.wr_data),
        .busy_o      (pipe_busy)
    );

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.rd_en     = step;
    assign bus.rd_addr_a = addr_a_q;
    assign bus.rd_addr_b = addr_b_q;
    assign bus.alu_op    = op_q;
    assign bus.alu_q     = q_q;
    assign bus.alu_mu    = mu_q;
    assign bus.done      = (state_q == ST_DONE);
    assign bus.err       = (state_q == ST_DONE) && err_q;

endmodule

// File: doc/vec_op_seq.md
Name: vec_op_seq

Overview:
- Command-driven sequencer that initiates element-wise vector operations on the shared combinational modular ALU (add/sub/mult mod q).
- Streams operand pairs from two synchronous scratchpad read ports, drives opcode, operands, q and mu to the ALU, and writes each result to a third port.
- Sits between the top-level instruction decoder and the vector scratchpad banks.
- Sustains one element per clock.

Parameters:
- DATA_W, 64, coefficient and modulus width.
- ADDR_W, 10, scratchpad word-address width.
- LEN_W, 11, vector-length field width; must represent 0..2^ADDR_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  3  000 add, 001 sub, 010 mult; others illegal.
- cmd_src_a / cmd_src_b / cmd_dst  in  ADDR_W  base addresses.
- cmd_len  in  LEN_W  element count.
- cmd_q / cmd_mu  in  DATA_W  modulus and Barrett constant.
- rd_en  out  1  read strobe, common to both ports.
- rd_addr_a / rd_addr_b  out  ADDR_W  read addresses.
- rd_data_a / rd_data_b  in  DATA_W  read data, valid the cycle after rd_en.
- alu_op  out  3  to ALU opcode.
- alu_a / alu_b  out  DATA_W  registered operands.
- alu_q / alu_mu  out  DATA_W  latched q and mu.
- alu_res  in  DATA_W  combinational ALU result.
- wr_en  out  1  write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  registered result.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; illegal opcode.

Behaviour:
- **Reset**
  - All outputs go to 0; cmd_ready is 1 in the cycle after rst.
  - FSM enters IDLE and pipeline valids clear.
  - rst mid-operation aborts at once: no rd_en or wr_en from the next cycle on; in-flight elements are dropped.
- **FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE.**
  - IDLE: on cmd_valid && cmd_ready (cycle C0), latch every cmd_* field.
    - cmd_op > 010: go to DONE with err=1; no memory accesses.
    - cmd_len == 0: go to DONE with err=0; done pulses at C0+1.
    - Otherwise go to RUN.
  - RUN: in cycle C0+1+i, for i = 0..len-1:
    - rd_en=1.
    - rd_addr_a = (src_a+i) mod 2^ADDR_W; rd_addr_b = (src_b+i) mod 2^ADDR_W.
    - After the last issue, go to DRAIN.
  - DRAIN: holds until the last write has issued, then goes to DONE.
  - DONE: done=1 for exactly one cycle, err valid; then IDLE. cmd_ready=0 in DONE.
- **Pipeline (fixed, no stalls)**
  - Read issued at C0+1+i.
  - rd_data captured into alu_a/alu_b at the end of C0+2+i, so operands are valid during C0+3+i.
  - alu_res registered into wr_data at the end of C0+3+i.
  - wr_en=1 with wr_addr=(dst+i) mod 2^ADDR_W at C0+4+i.
  - Last write at C0+3+len; done at C0+4+len.
- alu_op, alu_q and alu_mu hold the latched values from C0+1 until the next command.
- alu_a and alu_b hold their last value when not valid.
- cmd_valid outside IDLE is ignored; the command is not latched.
- In-place operation (dst == src_a or src_b) is legal. Element i is read 3 cycles before its write, and element j>i is never overwritten earlier, so no hazard exists.
- Address wrap: base + i past 2^ADDR_W-1 wraps to 0.
- cmd_len > 2^ADDR_W is undefined; the decoder guarantees this does not occur.

Decomposition:
- Package vec_pkg:
  - Opcode constants OP_ADD=3'b000, OP_SUB=3'b001, OP_MUL=3'b010.
  - FSM state encoding (IDLE, RUN, DRAIN, DONE).
  - Pipeline depth constant SEQ_LAT=3, from read issue to write.
- Sub-module vec_seq_pipe: carries valid and address through the 3-stage operand/result pipeline, with clear on rst. The FSM and address counters stay in the top module.

Test Plan:
- add, q=17, len=2, A=[5,16], B=[14,3], dst=0x20 -> wr 0x20=2, 0x21=2. First wr_en at C0+4; done at C0+6, err=0.
- sub, q=17, A=[3], B=[5] -> wr_data=15. mult, q=17 with the bench's Barrett mu, A=[4], B=[5] -> wr_data=3.
- len=0 -> no rd_en or wr_en; done at C0+1, err=0. cmd_op=3'b101 -> no accesses; done with err=1.
- src_a=0x3FE, dst=0x3FF, len=4 -> rd_addr_a sequence 3FE,3FF,000,001; wr_addr sequence 3FF,000,001,002.
- In-place add, src_a=dst=0x10, len=8, B all 1, q=97 -> each A[i] becomes (A[i]+1) mod 97. cmd_valid pulsed mid-run is ignored, and cmd_ready=0 throughout.
- rst asserted at C0+5 of a len=16 command -> wr_en=0 from the next cycle; cmd_ready=1 after rst; a new command is accepted and completes correctly.
